// File: rtl/rv32imc_types.sv
// Shared types and default sizing for the in-order pipeline control slice.
package rv32imc_types;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_fsm_t;

   localparam int DEF_NUM_STAGES    = 5;
   localparam int DEF_HAZARD_STAGES = 2;
   localparam int DEF_FLUSH_STAGE   = 2;
   localparam int DEF_ORDER_W       = 64;
   localparam int DEF_CNT_W         = 32;

endpackage

// File: rtl/mem_port_fsm.sv
// Single-outstanding request tracker for one memory port: produces the
// port stall and a sticky protocol-error flag.
module mem_port_fsm
   import rv32imc_types::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic resp,
   output logic stall,
   output logic err
);

   mem_fsm_t state_q, state_d;
   logic     err_q, err_d;

   // A req while already waiting (without the closing resp) is dropped.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (resp) err_d = 1'b1;
            if (req)  state_d = WAIT;
         end
         WAIT: begin
            if (resp && !req)      state_d = IDLE;
            else if (req && !resp) err_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   assign stall = (state_q == WAIT) && !resp;
   assign err   = err_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline register control: per-stage write enables and valid bits,
// hazard bubbles, flushes, retirement ordering and performance counters.
module pipe_ctrl
   import rv32imc_types::*;
#(
   parameter int NUM_STAGES    = DEF_NUM_STAGES,
   parameter int HAZARD_STAGES = DEF_HAZARD_STAGES,
   parameter int FLUSH_STAGE   = DEF_FLUSH_STAGE,
   parameter int ORDER_W       = DEF_ORDER_W,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_valid,
   input  logic                  imem_req,
   input  logic                  imem_resp,
   input  logic                  dmem_req,
   input  logic                  dmem_resp,
   input  logic                  load_hazard,
   input  logic                  flush,
   output logic [NUM_STAGES-1:0] stage_we,
   output logic [NUM_STAGES-1:0] stage_valid,
   output logic                  imem_stall,
   output logic                  dmem_stall,
   output logic                  retire_valid,
   output logic [ORDER_W-1:0]    retire_order,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      hazard_cycles,
   output logic [CNT_W-1:0]      flush_count,
   output logic                  proto_err
);

   logic                  gstall, hold_hazard, flush_apply;
   logic                  imem_err, dmem_err;
   logic [NUM_STAGES-1:0] shift_in;
   logic [NUM_STAGES-1:0] stage_valid_q, stage_valid_d;
   logic                  retire_fresh_q, retire_fresh_d;
   logic [ORDER_W-1:0]    retire_order_q, retire_order_d;
   logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0]      hazard_cycles_q, hazard_cycles_d;
   logic [CNT_W-1:0]      flush_count_q, flush_count_d;

   mem_port_fsm u_imem (
      .clk   (clk),
      .rst   (rst),
      .req   (imem_req),
      .resp  (imem_resp),
      .stall (imem_stall),
      .err   (imem_err)
   );

   mem_port_fsm u_dmem (
      .clk   (clk),
      .rst   (rst),
      .req   (dmem_req),
      .resp  (dmem_resp),
      .stall (dmem_stall),
      .err   (dmem_err)
   );

   // Flush wins over a hazard, but only once the memories stop stalling.
   assign gstall      = imem_stall | dmem_stall;
   assign hold_hazard = load_hazard && !flush;
   assign flush_apply = flush && !gstall;
   assign shift_in    = {stage_valid_q[NUM_STAGES-2:0], fetch_valid};

   always_comb begin
      stage_we = '0;
      for (int i = 0; i < NUM_STAGES; i++)
         stage_we[i] = !gstall && !(hold_hazard && (i < HAZARD_STAGES));
   end

   always_comb begin
      stage_valid_d = stage_valid_q;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (stage_we[i]) begin
            if (flush_apply && (i <= FLUSH_STAGE))
               stage_valid_d[i] = 1'b0;
            else if (hold_hazard && (i == HAZARD_STAGES))
               stage_valid_d[i] = 1'b0;
            else
               stage_valid_d[i] = shift_in[i];
         end
      end
   end

   // retire_fresh marks the first cycle an instruction sits in writeback.
   always_comb begin
      retire_fresh_d  = stage_we[NUM_STAGES-1] && shift_in[NUM_STAGES-1];
      retire_order_d  = retire_order_q;
      stall_cycles_d  = stall_cycles_q;
      hazard_cycles_d = hazard_cycles_q;
      flush_count_d   = flush_count_q;
      if (retire_valid)
         retire_order_d = retire_order_q + ORDER_W'(1);
      if (gstall && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if (load_hazard && !gstall && !flush && (hazard_cycles_q != '1))
         hazard_cycles_d = hazard_cycles_q + CNT_W'(1);
      if (flush_apply && (flush_count_q != '1))
         flush_count_d = flush_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_valid_q   <= '0;
         retire_fresh_q  <= 1'b0;
         retire_order_q  <= '0;
         stall_cycles_q  <= '0;
         hazard_cycles_q <= '0;
         flush_count_q   <= '0;
      end else begin
         stage_valid_q   <= stage_valid_d;
         retire_fresh_q  <= retire_fresh_d;
         retire_order_q  <= retire_order_d;
         stall_cycles_q  <= stall_cycles_d;
         hazard_cycles_q <= hazard_cycles_d;
         flush_count_q   <= flush_count_d;
      end
   end

   assign stage_valid   = stage_valid_q;
   assign retire_valid  = stage_valid_q[NUM_STAGES-1] && retire_fresh_q;
   assign retire_order  = retire_order_q;
   assign stall_cycles  = stall_cycles_q;
   assign hazard_cycles = hazard_cycles_q;
   assign flush_count   = flush_count_q;
   assign proto_err     = imem_err | dmem_err;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl at default parameters 5/2/2.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_valid = 1'b0, imem_req = 1'b0, imem_resp = 1'b0;
   logic        dmem_req = 1'b0, dmem_resp = 1'b0, load_hazard = 1'b0, flush = 1'b0;
   logic [4:0]  stage_we, stage_valid;
   logic        imem_stall, dmem_stall, retire_valid, proto_err;
   logic [63:0] retire_order;
   logic [31:0] stall_cycles, hazard_cycles, flush_count;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic        fv, ir, irs, dr, drs, lh, fl;
      logic [4:0]  we, valid;
      logic        istall, dstall, ret, perr;
      logic [63:0] order;
   } vec_t;

   vec_t vecs[14];

   pipe_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_valid   (fetch_valid),
      .imem_req      (imem_req),
      .imem_resp     (imem_resp),
      .dmem_req      (dmem_req),
      .dmem_resp     (dmem_resp),
      .load_hazard   (load_hazard),
      .flush         (flush),
      .stage_we      (stage_we),
      .stage_valid   (stage_valid),
      .imem_stall    (imem_stall),
      .dmem_stall    (dmem_stall),
      .retire_valid  (retire_valid),
      .retire_order  (retire_order),
      .stall_cycles  (stall_cycles),
      .hazard_cycles (hazard_cycles),
      .flush_count   (flush_count),
      .proto_err     (proto_err)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic applyStimulus(input logic fv, ir, irs, dr, drs, lh, fl, r);
      @(negedge clk);
      fetch_valid = fv;
      imem_req    = ir;
      imem_resp   = irs;
      dmem_req    = dr;
      dmem_resp   = drs;
      load_hazard = lh;
      flush       = fl;
      rst         = r;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic resetDut();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      int nret;

      vecs[0]  = '{1,0,0,0,0,0,0, 5'b11111, 5'b00000, 0,0,0,0, 64'd0};
      vecs[1]  = '{1,0,0,0,0,0,0, 5'b11111, 5'b00001, 0,0,0,0, 64'd0};
      vecs[2]  = '{1,0,0,0,0,0,0, 5'b11111, 5'b00011, 0,0,0,0, 64'd0};
      vecs[3]  = '{1,0,0,0,0,0,0, 5'b11111, 5'b00111, 0,0,0,0, 64'd0};
      vecs[4]  = '{1,0,0,0,0,0,0, 5'b11111, 5'b01111, 0,0,0,0, 64'd0};
      vecs[5]  = '{1,0,0,0,0,1,0, 5'b11100, 5'b11111, 0,0,1,0, 64'd0};
      vecs[6]  = '{1,0,0,0,0,0,0, 5'b11111, 5'b11011, 0,0,1,0, 64'd1};
      vecs[7]  = '{1,0,0,0,0,1,1, 5'b11111, 5'b10111, 0,0,1,0, 64'd2};
      vecs[8]  = '{0,0,0,0,0,0,0, 5'b11111, 5'b01000, 0,0,0,0, 64'd3};
      vecs[9]  = '{0,1,0,0,0,0,0, 5'b11111, 5'b10000, 0,0,1,0, 64'd3};
      vecs[10] = '{1,0,0,0,0,0,0, 5'b00000, 5'b00000, 1,0,0,0, 64'd4};
      vecs[11] = '{1,0,1,0,0,0,0, 5'b11111, 5'b00000, 0,0,0,0, 64'd4};
      vecs[12] = '{0,0,0,0,1,0,0, 5'b11111, 5'b00001, 0,0,0,0, 64'd4};
      vecs[13] = '{0,0,0,0,0,0,0, 5'b11111, 5'b00010, 0,0,0,1, 64'd4};

      resetDut();
      resetDut();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rst_valid", 64'(stage_valid), 64'd0);
      checkOutput("rst_we", 64'(stage_we), 64'h1f);
      checkOutput("rst_retire", 64'(retire_valid), 64'd0);
      checkOutput("rst_order", retire_order, 64'd0);
      checkOutput("rst_stall", 64'({imem_stall, dmem_stall}), 64'd0);
      checkOutput("rst_cnt", 64'(stall_cycles | hazard_cycles | flush_count), 64'd0);
      checkOutput("rst_perr", 64'(proto_err), 64'd0);

      // Fill, hazard bubble, flush over hazard, imem stall, dmem protocol error.
      for (int k = 0; k < 14; k++) begin
         applyStimulus(vecs[k].fv, vecs[k].ir, vecs[k].irs, vecs[k].dr,
                       vecs[k].drs, vecs[k].lh, vecs[k].fl, 0);
         checkOutput($sformatf("v%0d_we", k), 64'(stage_we), 64'(vecs[k].we));
         checkOutput($sformatf("v%0d_valid", k), 64'(stage_valid), 64'(vecs[k].valid));
         checkOutput($sformatf("v%0d_istall", k), 64'(imem_stall), 64'(vecs[k].istall));
         checkOutput($sformatf("v%0d_dstall", k), 64'(dmem_stall), 64'(vecs[k].dstall));
         checkOutput($sformatf("v%0d_retire", k), 64'(retire_valid), 64'(vecs[k].ret));
         checkOutput($sformatf("v%0d_perr", k), 64'(proto_err), 64'(vecs[k].perr));
         checkOutput($sformatf("v%0d_order", k), retire_order, vecs[k].order);
      end
      checkOutput("tbl_stall_cycles", 64'(stall_cycles), 64'd1);
      checkOutput("tbl_hazard_cycles", 64'(hazard_cycles), 64'd1);
      checkOutput("tbl_flush_count", 64'(flush_count), 64'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("perr_sticky", 64'(proto_err), 64'd1);

      // Back-to-back: pipelined imem requests, ten instructions retire in order.
      resetDut();
      nret = 0;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(c < 10, c < 10, (c >= 1) && (c <= 10), 0, 0, 0, 0, 0);
         if (retire_valid) begin
            checkOutput($sformatf("b2b_order%0d", nret), retire_order, 64'(nret));
            nret++;
         end
      end
      checkOutput("b2b_retires", 64'(nret), 64'd10);
      checkOutput("b2b_order_end", retire_order, 64'd10);
      checkOutput("b2b_stall_cycles", 64'(stall_cycles), 64'd0);
      checkOutput("b2b_perr", 64'(proto_err), 64'd0);

      // Imem wait: response three cycles after the request, writeback occupied.
      resetDut();
      nret = 0;
      for (int c = 0; c < 12; c++) begin
         logic exp_stall;
         exp_stall = (c == 5) || (c == 6);
         applyStimulus(c == 0, c == 4, c == 7, 0, 0, 0, 0, 0);
         checkOutput($sformatf("iw_stall%0d", c), 64'(imem_stall), 64'(exp_stall));
         checkOutput($sformatf("iw_we%0d", c), 64'(stage_we), exp_stall ? 64'd0 : 64'h1f);
         if (retire_valid) nret++;
      end
      checkOutput("iw_retires", 64'(nret), 64'd1);
      checkOutput("iw_stall_cycles", 64'(stall_cycles), 64'd2);
      checkOutput("iw_perr", 64'(proto_err), 64'd0);

      // Reset while dmem is waiting; the orphaned response is a protocol error.
      resetDut();
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("rw_dstall_pre", 64'(dmem_stall), 64'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rw_dstall", 64'(dmem_stall), 64'd0);
      checkOutput("rw_valid", 64'(stage_valid), 64'd0);
      checkOutput("rw_stall_cycles", 64'(stall_cycles), 64'd0);
      checkOutput("rw_perr0", 64'(proto_err), 64'd0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("rw_perr_same", 64'(proto_err), 64'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rw_perr1", 64'(proto_err), 64'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rw_perr_hold", 64'(proto_err), 64'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5: number of pipeline registers (legal 3..8); register 0 is fetch, NUM_STAGES-1 is writeback.
REQ-002 SHALL have parameter HAZARD_STAGES, default 2: registers 0..HAZARD_STAGES-1 hold on load hazard (legal 1..NUM_STAGES-2).
REQ-003 SHALL have parameter FLUSH_STAGE, default 2: register whose instruction raises flush (legal HAZARD_STAGES..NUM_STAGES-2).
REQ-004 SHALL have parameters ORDER_W, default 64, retire order width; and CNT_W, default 32, perf counter width.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-006 SHALL have inputs: fetch_valid 1, new instruction offered to register 0; imem_req/imem_resp 1/1; dmem_req/dmem_resp 1/1; load_hazard 1; flush 1.
REQ-007 SHALL have outputs: stage_we [NUM_STAGES]; stage_valid [NUM_STAGES]; imem_stall 1; dmem_stall 1.
REQ-008 SHALL have outputs: retire_valid 1; retire_order [ORDER_W]; stall_cycles, hazard_cycles, flush_count [CNT_W] each; proto_err 1.

Function
REQ-009 SHALL keep one 2-state FSM per memory port (IDLE, WAIT).
- IDLE: req -> WAIT.
- WAIT: resp & !req -> IDLE; resp & req -> WAIT.
REQ-010 SHALL drive imem_stall = (imem FSM == WAIT) & !imem_resp combinationally; dmem_stall likewise.
REQ-011 SHALL define gstall = imem_stall | dmem_stall.
REQ-012 SHALL drive stage_we[i] = !gstall & !(load_hazard & i < HAZARD_STAGES & !flush).
REQ-013 SHALL update stage_valid on enabled registers only:
- register 0 loads fetch_valid;
- register i loads stage_valid[i-1];
- register HAZARD_STAGES loads 0 (bubble) when load_hazard & !flush.
REQ-014 SHALL, on flush & !gstall, load 0 into registers 0..FLUSH_STAGE; register FLUSH_STAGE+1 loads normally; flush overrides load_hazard.
REQ-015 SHALL ignore flush while gstall is high (source holds it).
REQ-016 SHALL assert retire_valid for exactly one cycle per valid instruction in register NUM_STAGES-1.
- Mechanism: retire_fresh flop set when stage_we[NUM_STAGES-1] loads valid, else cleared.
- retire_valid = stage_valid[NUM_STAGES-1] & retire_fresh.
- Stalls never duplicate a retirement.
REQ-017 SHALL present retire_order = number of prior retirements (first = 0); it increments after each retire_valid and wraps modulo 2^ORDER_W.
REQ-018 SHALL increment perf counters as follows, each saturating at all-ones:
- stall_cycles: each gstall cycle;
- hazard_cycles: each load_hazard & !gstall & !flush cycle;
- flush_count: each applied flush (REQ-014).
REQ-019 SHALL set proto_err sticky on a resp in IDLE, or a req in WAIT without same-cycle resp; the offending req is ignored.
REQ-020 SHALL have no combinational path from flush or load_hazard to imem_stall or dmem_stall.

Reset
REQ-021 SHALL, on rst, set FSMs IDLE and zero stage_valid, retire_fresh, retire_order, all counters and proto_err.
REQ-022 SHALL give rst priority over every concurrent event; reset mid-WAIT discards the outstanding request, and a later resp raises proto_err.

Structure
REQ-023 SHALL place the mem_fsm_t enum (IDLE, WAIT) and default parameter constants in rv32imc_types.
REQ-024 SHALL instantiate sub-module mem_port_fsm twice (imem, dmem), each outputting stall and err.

Verification
REQ-025 SHALL cover these scenarios with defaults 5/2/2:
- Back-to-back: fetch_valid=1 for 10 cycles, resp same cycle as req, no hazards -> 10 retire_valid pulses, retire_order 0..9, stall_cycles=0.
- Imem wait: imem_req, resp 3 cycles later -> imem_stall high 2 cycles, stage_we=0 those cycles, stall_cycles=2, no duplicate retire.
- Load hazard: 1 cycle with full pipe -> stage_we=5'b11100, bubble in register 2, hazard_cycles=1, retirement count drops by exactly one.
- Flush with simultaneous load_hazard: all stages valid -> registers 0..2 invalid next cycle, register 3 valid, flush_count=1, hazard_cycles=0.
- Protocol error: dmem_resp with FSM IDLE -> proto_err=1 and sticky until rst.
- Reset mid-WAIT: rst during WAIT -> all outputs zero next cycle; subsequent resp sets proto_err.
